// File: rtl/serial_addsub_16bit_pkg.sv
// Shared constants and types for the bit-serial adder/subtractor.
package serial_addsub_16bit_pkg;

  localparam int unsigned ADDSUB_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full-adder cell; the only arithmetic in the serial datapath.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum_c,
  output logic cout_c
);

  assign sum_c  = a ^ b ^ ci;
  assign cout_c = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub_16bit.sv
// Bit-serial X+Y / X-Y, one bit per cycle LSB first, with registered result and flags.
module serial_addsub_16bit
  import serial_addsub_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Z,
  output logic             s,
  output logic             zr,
  output logic             cy,
  output logic             p,
  output logic             v
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             load_c, shift_c, finish_c;
  logic [WIDTH-1:0] x_sr, y_sr, z_sr;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  op_e              op_q;
  logic             fa_b_c, sum_c, cout_c;
  logic [WIDTH-1:0] z_fin_c;

  // Subtraction feeds the inverted Y bit; the +1 comes from the preset carry.
  assign fa_b_c  = y_sr[0] ^ (op_q == OP_SUB);
  assign z_fin_c = {sum_c, z_sr[WIDTH-1:1]};

  full_adder_1bit u_fa (
    .a      (x_sr[0]),
    .b      (fa_b_c),
    .ci     (carry_q),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    shift_c  = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        shift_c = 1'b1;
        if (cnt_q == LAST_BIT) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand/result shift registers, bit counter and carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sr    <= '0;
      y_sr    <= '0;
      z_sr    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_ADD;
    end else if (load_c) begin
      x_sr    <= X;
      y_sr    <= Y;
      cnt_q   <= '0;
      carry_q <= sub;
      op_q    <= op_e'(sub);
    end else if (shift_c) begin
      x_sr    <= x_sr >> 1;
      y_sr    <= y_sr >> 1;
      z_sr    <= z_fin_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      carry_q <= cout_c;
    end
  end

  // Status, result and flags; result/flags change only when DONE is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      Z    <= '0;
      s    <= 1'b0;
      zr   <= 1'b0;
      cy   <= 1'b0;
      p    <= 1'b0;
      v    <= 1'b0;
    end else begin
      busy <= (state_d == RUN);
      done <= finish_c;
      if (finish_c) begin
        Z  <= z_fin_c;
        s  <= z_fin_c[WIDTH-1];
        zr <= (z_fin_c == '0);
        cy <= cout_c;
        p  <= ~^z_fin_c;
        v  <= cout_c ^ carry_q;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_16bit.sv
// Randomized and directed checks of serial_addsub_16bit against an arithmetic reference model.
module tb_serial_addsub_16bit;

  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [15:0] X, Y, Z;
  logic        busy, done, s, zr, cy, p, v;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] prev_z;
  logic [4:0]  prev_f;

  serial_addsub_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .X(X), .Y(Y),
    .busy(busy), .done(done), .Z(Z), .s(s), .zr(zr), .cy(cy), .p(p), .v(v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic; overflow from operand/result signs, carry as unsigned compare.
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b, input logic op);
    int unsigned sum;
    logic [15:0] z;
    logic c, ov;
    if (op) begin
      z  = a - b;
      c  = (a >= b);
      ov = (a[15] != b[15]) && (z[15] != a[15]);
    end else begin
      sum = 32'(a) + 32'(b);
      z   = sum[15:0];
      c   = (sum > 32'hffff);
      ov  = (a[15] == b[15]) && (z[15] != a[15]);
    end
    return {z, z[15], (z == 16'h0), c, (($countones(z) % 2) == 0), ov};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic op);
    X = a; Y = b; sub = op; start = 1'b1;
    step();
    start = 1'b0;
    X = 16'($urandom); Y = 16'($urandom); sub = 1'($urandom);
    check("busy_run", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input bit noisy);
    int n = 0;
    while (!done && n < 40) begin
      if (n == 5) begin
        check("hold_z", 32'(Z), 32'(prev_z));
        check("hold_flags", 32'({s, zr, cy, p, v}), 32'(prev_f));
      end
      if (noisy && (n == 3 || n == 9)) begin
        start = 1'b1; X = 16'($urandom); Y = 16'($urandom); sub = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      step();
      n++;
    end
    start = 1'b0;
    check("latency", 32'(n), 32'd16);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic op, input bit noisy);
    logic [20:0] exp;
    exp = model(a, b, op);
    launch(a, b, op);
    wait_done(noisy);
    check("z", 32'(Z), 32'(exp[20:5]));
    check("flags", 32'({s, zr, cy, p, v}), 32'(exp[4:0]));
    check("busy_done", 32'(busy), 32'd0);
    prev_z = exp[20:5];
    prev_f = exp[4:0];
  endtask

  initial begin
    int n_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; X = '0; Y = '0;
    prev_z = '0; prev_f = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", 32'({done, Z, s, zr, cy, p, v}), 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    do_op(16'h8fff, 16'h8000, 1'b0, 1'b0);
    step();
    check("done_pulse", 32'({done, busy}), 32'd0);
    do_op(16'hfffe, 16'h0002, 1'b0, 1'b0);
    do_op(16'haaaa, 16'h5555, 1'b0, 1'b0);
    step();
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b1, 1'b0);
    step();
    do_op(16'h1234, 16'h0777, 1'b0, 1'b1);
    step();
    check("single_done", 32'({done, busy}), 32'd0);

    // Abort mid-RUN with an asynchronous reset
    launch(16'h00ff, 16'h0101, 1'b0);
    repeat (7) step();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_outs", 32'({done, Z, s, zr, cy, p, v}), 32'd0);
    step();
    rst = 1'b0;
    prev_z = '0; prev_f = '0;
    n_done = 0;
    repeat (25) begin
      step();
      if (done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = int'($urandom_range(2, 0));
      repeat (gap) step();
      do_op(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_addsub_16bit.md
SERIAL_ADDSUB_16BIT -- requirements
Module: serial_addsub_16bit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; only 16 is required to be supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a new operation.
REQ-005 SHALL have port sub  input  1  0 = X+Y, 1 = X-Y; sampled with start.
REQ-006 SHALL have ports X, Y  input  16 each  operands; sampled with start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when result and flags are valid.
REQ-009 SHALL have port Z  output  16  result.
REQ-010 SHALL have ports s, zr, cy, p, v  output  1 each  sign, zero, carry, parity and overflow flags.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: start=1 -> latch X, Y, sub; clear bit counter; carry = sub; go to RUN. start=0 -> stay in IDLE.
REQ-013 RUN: one bit per cycle, LSB first; sum bit = Xi ^ Yi' ^ c, where Yi' = Yi ^ sub; carry updated from the same full-adder cell.
REQ-014 RUN SHALL last exactly 16 cycles, then go to DONE; busy=1 throughout RUN.
REQ-015 Latency: start accepted at edge 0; done=1 during cycle 17 only; busy=0 in IDLE and DONE.
REQ-016 Z, s, zr, cy, p, v SHALL update only on entry to DONE and hold until the next DONE entry or reset.
REQ-017 Z SHALL hold the low 16 bits of X+Y (sub=0) or X+~Y+1 (sub=1).
REQ-018 s = Z[15].
REQ-019 zr = 1 iff Z == 0.
REQ-020 cy = carry out of bit 15; for subtraction, 1 means no borrow.
REQ-021 p = 1 iff Z contains an even number of 1 bits.
REQ-022 v = two's-complement overflow: carry into bit 15 XOR carry out of bit 15.
REQ-023 DONE: start=1 -> accept the new operation per REQ-012 (back-to-back, no idle cycle); otherwise -> IDLE.
REQ-024 start asserted during RUN SHALL be ignored; the operands and the operation in flight SHALL be unaffected.
REQ-025 Z and flags SHALL remain stable while a new operation runs, until its DONE.

Reset
REQ-026 rst=1 SHALL immediately force IDLE, without waiting for a clock edge, and clear busy, done, Z, s, zr, cy, p, v, the counter, the carry and the operand registers to 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be honoured normally.

Structure
REQ-028 A shared package SHALL hold the WIDTH constant, the FSM state enum and the op encoding (ADD=0, SUB=1).
REQ-029 The 1-bit full-adder cell SHALL be a separate sub-module named full_adder_1bit, instantiated once.
REQ-030 Operand shifting SHALL use right-shift registers; Z SHALL be assembled in a right-shift register.

Verification
REQ-031 The bench SHALL cover add, sub=0, X=8fff, Y=8000 -> Z=0fff, s0 zr0 cy1 p1 v1; done exactly 17 cycles after start.
REQ-032 The bench SHALL cover add, X=fffe, Y=0002 -> Z=0000, s0 zr1 cy1 p1 v0.
REQ-033 The bench SHALL cover add, X=AAAA, Y=5555 -> Z=ffff, s1 zr0 cy0 p1 v0.
REQ-034 The bench SHALL cover sub, X=8000, Y=0001 -> Z=7fff, s0 zr0 cy1 p0 v1; then, back-to-back in the DONE cycle, sub X=0000, Y=0001 -> Z=ffff, s1 zr0 cy0 p1 v0.
REQ-035 The bench SHALL cover start pulses during RUN -> ignored, single done, result of the first operation only.
REQ-036 The bench SHALL cover rst at RUN cycle 8 -> busy=0 and all outputs 0 immediately, no done; a following add 0001+0001 -> Z=0002.
